// File: rtl/icache.sv
// Direct-mapped read-only instruction cache, one 32-bit word per line.
// Misses refill byte-by-byte from a byte-wide memory read port.
module icache #(
  parameter int ADDR_BITS  = 18,
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clr,
  input  logic [31:0] addr,
  input  logic        rn,
  output logic [31:0] Inst,
  output logic        Read_ready,
  output logic        Mem_rn,
  output logic [31:0] Mem_addr,
  input  logic [7:0]  Mem_data,
  input  logic        Mem_ready
);

  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 2;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int REQ_BITS = ADDR_BITS - 2;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RESP
  } state_e;

  state_e               state_q, state_d;
  logic [31:0]          inst_q, inst_d;
  logic                 rr_q, rr_d;
  logic                 mrn_q, mrn_d;
  logic [31:0]          maddr_q, maddr_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [REQ_BITS-1:0]  req_q, req_d;
  logic [23:0]          buf_q, buf_d;
  logic                 we;

  logic [LINES-1:0]     valid_q;
  logic [TAG_BITS-1:0]  tag_q  [LINES];
  logic [31:0]          data_q [LINES];

  logic [INDEX_BITS-1:0] a_idx;
  logic [TAG_BITS-1:0]   a_tag;
  logic [INDEX_BITS-1:0] r_idx;
  logic [TAG_BITS-1:0]   r_tag;
  logic                  hit;
  logic [31:0]           fill_word;
  logic                  unused_addr;

  assign a_idx       = addr[INDEX_BITS+1:2];
  assign a_tag       = addr[ADDR_BITS-1:INDEX_BITS+2];
  assign r_idx       = req_q[INDEX_BITS-1:0];
  assign r_tag       = req_q[REQ_BITS-1:INDEX_BITS];
  assign hit         = valid_q[a_idx] && (tag_q[a_idx] == a_tag);
  assign fill_word   = {Mem_data, buf_q};
  assign unused_addr = ^addr[1:0];

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    rr_d    = rr_q;
    mrn_d   = mrn_q;
    maddr_d = maddr_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    buf_d   = buf_q;
    we      = 1'b0;
    if (clr) begin
      // Abort: drop any partial fill and any response due this edge.
      state_d = IDLE;
      mrn_d   = 1'b0;
      rr_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          rr_d = 1'b0;
          if (rn) begin
            req_d = addr[ADDR_BITS-1:2];
            if (hit) begin
              inst_d  = data_q[a_idx];
              rr_d    = 1'b1;
              state_d = RESP;
            end else begin
              mrn_d   = 1'b1;
              maddr_d = {addr[31:2], 2'b00};
              cnt_d   = 2'd0;
              state_d = FILL;
            end
          end
        end
        FILL: begin
          if (Mem_ready) begin
            if (cnt_q != 2'd3) begin
              unique case (cnt_q)
                2'd0:    buf_d[7:0]   = Mem_data;
                2'd1:    buf_d[15:8]  = Mem_data;
                default: buf_d[23:16] = Mem_data;
              endcase
              cnt_d   = cnt_q + 2'd1;
              maddr_d = maddr_q + 32'd1;
            end else begin
              we      = 1'b1;
              mrn_d   = 1'b0;
              inst_d  = fill_word;
              rr_d    = 1'b1;
              state_d = RESP;
            end
          end
        end
        RESP: begin
          rr_d    = 1'b0;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      inst_q  <= '0;
      rr_q    <= 1'b0;
      mrn_q   <= 1'b0;
      maddr_q <= '0;
      cnt_q   <= '0;
      req_q   <= '0;
      buf_q   <= '0;
      valid_q <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      inst_q  <= inst_d;
      rr_q    <= rr_d;
      mrn_q   <= mrn_d;
      maddr_q <= maddr_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      buf_q   <= buf_d;
      if (we) valid_q[r_idx] <= 1'b1;
    end
  end

  // Tag/data arrays need no reset; validity gates every use.
  always_ff @(posedge clk) begin
    if (!rst && rdy && we) begin
      tag_q[r_idx]  <= r_tag;
      data_q[r_idx] <= fill_word;
    end
  end

  assign Inst       = inst_q;
  assign Read_ready = rr_q;
  assign Mem_rn     = mrn_q;
  assign Mem_addr   = maddr_q;

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: directed fetches, byte-wide memory
// responder, and a monitor that checks each Read_ready pulse.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst, rdy, clr, rn;
  logic [31:0] addr;
  logic [7:0]  Mem_data = 8'h00;
  logic        Mem_ready = 1'b0;
  logic [31:0] Inst;
  logic        Read_ready;
  logic        Mem_rn;
  logic [31:0] Mem_addr;

  always #5 clk = ~clk;

  icache dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .clr       (clr),
    .addr      (addr),
    .rn        (rn),
    .Inst      (Inst),
    .Read_ready(Read_ready),
    .Mem_rn    (Mem_rn),
    .Mem_addr  (Mem_addr),
    .Mem_data  (Mem_data),
    .Mem_ready (Mem_ready)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] log_q[$];
  int          exp_cnt  = 0;
  int          resp_cnt = 0;
  int          cyc      = 0;
  int          last_rr  = 0;
  logic        rr_prev  = 1'b0;
  int          mem_wait = 0;
  int          wcnt     = 0;

  function automatic logic [7:0] mb(input logic [31:0] a);
    case (a)
      32'h0:   return 8'h13;
      32'h1:   return 8'h05;
      32'h2:   return 8'h10;
      32'h3:   return 8'h00;
      default: return a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] mw(input logic [31:0] a);
    return {mb(a + 3), mb(a + 2), mb(a + 1), mb(a)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Memory controller model: Mem_ready after mem_wait idle cycles.
  always @(negedge clk) begin
    Mem_ready = 1'b0;
    if (Mem_rn) begin
      if (wcnt >= mem_wait) begin
        Mem_ready = 1'b1;
        Mem_data  = mb(Mem_addr);
        wcnt      = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  always @(posedge clk) begin
    if (!rst && rdy && !clr && Mem_rn && Mem_ready)
      log_q.push_back(Mem_addr);
  end

  always @(negedge clk) begin
    if (Read_ready && !rr_prev) begin
      resp_cnt++;
      last_rr = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got Inst %h, required none", Inst);
      end else begin
        chk("inst", Inst, exp_q.pop_front());
      end
    end
    rr_prev = Read_ready;
  end

  task automatic issue(input logic [31:0] a, input logic miss,
                       input bit push, input logic [31:0] ex);
    @(negedge clk);
    addr = a;
    rn   = 1'b1;
    if (push) begin
      exp_q.push_back(ex);
      exp_cnt++;
    end
    @(posedge clk);
    #1 rn = 1'b0;
    @(negedge clk);
    chk("mem_rn_after_sample", {31'd0, Mem_rn}, {31'd0, miss});
    if (!miss) chk("hit_latency", {31'd0, Read_ready}, 32'd1);
  endtask

  task automatic wait_resp(input string nm);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      #1;
      if (resp_cnt >= exp_cnt) begin
        n_checks++;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s timeout: got %0d responses, required %0d",
             nm, resp_cnt, exp_cnt);
  endtask

  task automatic wait_maddr(input logic [31:0] v);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (Mem_addr == v) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_mem_addr timeout: got %h, required %h", Mem_addr, v);
  endtask

  task automatic chk_log(input logic [31:0] base);
    chk("mem_req_count", log_q.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("mem_addr_seq",
          (i < log_q.size()) ? log_q[i] : 32'hFFFF_FFFF,
          base + i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst  = 1'b1;
    rdy  = 1'b1;
    clr  = 1'b0;
    rn   = 1'b0;
    addr = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_read_ready", {31'd0, Read_ready}, 32'd0);
    chk("reset_mem_rn", {31'd0, Mem_rn}, 32'd0);
    chk("reset_inst", Inst, 32'h0);
    chk("reset_mem_addr", Mem_addr, 32'h0);

    // Cold miss
    log_q.delete();
    issue(32'h0, 1'b1, 1'b1, 32'h0010_0513);
    wait_resp("cold_miss");
    chk("cold_mem_rn_drop", {31'd0, Mem_rn}, 32'd0);
    chk_log(32'h0);

    // Hit
    issue(32'h0, 1'b0, 1'b1, 32'h0010_0513);
    wait_resp("hit");

    // Preload 0x4 then back-to-back hits
    issue(32'h4, 1'b1, 1'b1, mw(32'h4));
    wait_resp("preload4");
    begin
      int t0;
      @(negedge clk);
      addr = 32'h0;
      rn   = 1'b1;
      exp_q.push_back(32'h0010_0513);
      exp_cnt++;
      wait_resp("b2b_0");
      t0   = last_rr;
      addr = 32'h4;
      exp_q.push_back(mw(32'h4));
      exp_cnt++;
      wait_resp("b2b_4");
      rn = 1'b0;
      chk("b2b_spacing", last_rr - t0, 32'd2);
    end

    // Conflict at index 0
    log_q.delete();
    issue(32'h100, 1'b1, 1'b1, mw(32'h100));
    wait_resp("conflict_100");
    chk_log(32'h100);
    log_q.delete();
    issue(32'h0, 1'b1, 1'b1, 32'h0010_0513);
    wait_resp("conflict_0");
    chk_log(32'h0);

    // Flush mid-fill
    issue(32'h40, 1'b1, 1'b0, 32'h0);
    wait_maddr(32'h42);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    addr = 32'h80;
    rn   = 1'b1;
    exp_q.push_back(mw(32'h80));
    exp_cnt++;
    @(negedge clk);
    chk("flush_mem_rn", {31'd0, Mem_rn}, 32'd0);
    chk("flush_read_ready", {31'd0, Read_ready}, 32'd0);
    @(posedge clk);
    #1 rn = 1'b0;
    @(negedge clk);
    chk("flush_next_miss", {31'd0, Mem_rn}, 32'd1);
    wait_resp("flush_80");
    issue(32'h40, 1'b1, 1'b1, mw(32'h40));
    wait_resp("refetch_40");

    // Stall during fill
    mem_wait = 1;
    log_q.delete();
    issue(32'h200, 1'b1, 1'b1, mw(32'h200));
    wait_maddr(32'h201);
    rdy = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall_mem_addr", Mem_addr, 32'h201);
      chk("stall_mem_rn", {31'd0, Mem_rn}, 32'd1);
    end
    rdy = 1'b1;
    wait_resp("stall_200");
    chk_log(32'h200);
    mem_wait = 0;

    // Reset mid-fill of 0x0 with 0x4 valid
    issue(32'h100, 1'b1, 1'b1, mw(32'h100));
    wait_resp("evict_0");
    issue(32'h0, 1'b1, 1'b0, 32'h0);
    wait_maddr(32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_rn", {31'd0, Mem_rn}, 32'd0);
    chk("rst_read_ready", {31'd0, Read_ready}, 32'd0);
    chk("rst_inst", Inst, 32'h0);
    chk("rst_mem_addr", Mem_addr, 32'h0);
    issue(32'h4, 1'b1, 1'b1, mw(32'h4));
    wait_resp("post_rst_4");
    issue(32'h0, 1'b1, 1'b1, 32'h0010_0513);
    wait_resp("post_rst_0");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
